// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: machine word and RAM handshake state.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'b00,
    BUSY   = 2'b01,
    ACCESS = 2'b10,
    ERROR  = 2'b11
  } ramstate_t;

endpackage

// File: rtl/diaosi_types_pkg.sv
// Memory arbiter types: grant state, watchdog fill word, grant priority helper.
package diaosi_types_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    IGNT = 2'b01,
    DGNT = 2'b10
  } arb_state_t;

  // Returned to the requester when the watchdog forces a completion.
  localparam logic [31:0] ARB_BAD_LOAD = 32'hBAD1BAD1;

  // Data wins unless the instruction side has been starved; otherwise fetch.
  function automatic arb_state_t arb_pick(input logic dreq, input logic ireq,
                                          input logic starved);
    if (dreq && !starved) return DGNT;
    else if (ireq)        return IGNT;
    else                  return IDLE;
  endfunction

endpackage

// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter: shares one RAM port between icache fetch and dcache
// load/store. Registered grant FSM, data priority, starvation counter that
// forces an instruction grant after STARVE_LIMIT back-to-back data grants.
// Optional build macro ARB_TIMEOUT_EN adds a per-grant watchdog that forces
// completion with ARB_BAD_LOAD and raises the sticky arb_err flag.
module mem_req_arbiter
  import cpu_types_pkg::*;
  import diaosi_types_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
`ifdef ARB_TIMEOUT_EN
  , parameter int unsigned TIMEOUT    = 255
`endif
) (
  input  logic      CLK,
  input  logic      nRST,
  input  logic      iREN,
  input  word_t     iaddr,
  output logic      iwait,
  output word_t     iload,
  input  logic      dREN,
  input  logic      dWEN,
  input  word_t     daddr,
  input  word_t     dstore,
  output logic      dwait,
  output word_t     dload,
  output logic      ramREN,
  output logic      ramWEN,
  output word_t     ramaddr,
  output word_t     ramstore,
  input  word_t     ramload,
  input  ramstate_t ramstate,
  output logic      arb_err
);

  localparam logic [3:0] LP_LIMIT = 4'(STARVE_LIMIT);

  arb_state_t r_state, w_state_nxt;
  logic [3:0] r_starve, w_starve_nxt;
  logic       w_dreq, w_access, w_fire, w_idone, w_ddone, w_starved;

  assign w_dreq   = dREN | dWEN;
  assign w_access = (ramstate == ACCESS);

`ifdef ARB_TIMEOUT_EN
  logic [7:0] r_wd;
  logic       r_err;

  assign w_fire  = (r_state != IDLE) && (r_wd == 8'(TIMEOUT));
  assign arb_err = r_err;

  // Watchdog: counts stalled granted cycles, restarts on any handoff or completion.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_wd  <= '0;
      r_err <= 1'b0;
    end else begin
      if (r_state == IDLE || w_state_nxt != r_state || w_access || w_idone || w_ddone)
        r_wd <= '0;
      else
        r_wd <= r_wd + 8'd1;
      if (w_fire && (w_idone || w_ddone))
        r_err <= 1'b1;
    end
  end
`else
  assign w_fire  = 1'b0;
  assign arb_err = 1'b0;
`endif

  // A completion is ACCESS (or a watchdog fire) on the granted, still-requesting side.
  assign w_idone = (r_state == IGNT) && iREN   && (w_access || w_fire);
  assign w_ddone = (r_state == DGNT) && w_dreq && (w_access || w_fire);

  assign iwait = iREN   & ~w_idone;
  assign dwait = w_dreq & ~w_ddone;

  // Starvation count as it will stand after this cycle; grant decisions use it.
  always_comb begin
    w_starve_nxt = r_starve;
    if (!iREN || w_idone)
      w_starve_nxt = '0;
    else if (w_ddone && r_starve != 4'hF)
      w_starve_nxt = r_starve + 4'd1;
  end

  assign w_starved = (w_starve_nxt >= LP_LIMIT);

  // Next grant: hold while the granted side waits, re-arbitrate on completion or withdrawal.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    w_state_nxt = arb_pick(w_dreq, iREN, w_starved);
      IGNT:    if (w_idone || !iREN)   w_state_nxt = arb_pick(w_dreq, iREN, w_starved);
      DGNT:    if (w_ddone || !w_dreq) w_state_nxt = arb_pick(w_dreq, iREN, w_starved);
      default: w_state_nxt = IDLE;
    endcase
  end

  // Grant state and starvation counter.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state  <= IDLE;
      r_starve <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_starve <= w_starve_nxt;
    end
  end

  // RAM port and load steering follow the registered grant; enables track the live request.
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iload    = '0;
    dload    = '0;
    unique case (r_state)
      IGNT: begin
        ramREN  = iREN;
        ramaddr = iaddr;
        iload   = w_fire ? ARB_BAD_LOAD : ramload;
      end
      DGNT: begin
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        ramaddr  = daddr;
        ramstore = dstore;
        dload    = w_fire ? ARB_BAD_LOAD : ramload;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter; inputs change 1ns after the rising
// edge, outputs are sampled 4ns after the rising edge.
module tb_mem_req_arbiter;
  import cpu_types_pkg::*;

  logic      CLK = 1'b0;
  logic      nRST;
  logic      iREN, dREN, dWEN;
  word_t     iaddr, daddr, dstore, ramload;
  ramstate_t ramstate;
  logic      iwait, dwait, ramREN, ramWEN, arb_err;
  word_t     iload, dload, ramaddr, ramstore;

  int checks   = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

`ifdef ARB_TIMEOUT_EN
  mem_req_arbiter #(.STARVE_LIMIT(4), .TIMEOUT(8)) dut (
`else
  mem_req_arbiter #(.STARVE_LIMIT(4)) dut (
`endif
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .arb_err(arb_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic smp();
    #3;
  endtask

  initial begin
    nRST = 1'b0; iREN = 0; dREN = 0; dWEN = 0;
    iaddr = '0; daddr = '0; dstore = '0; ramload = '0; ramstate = FREE;
    #12;
    // reset state
    chk("rst_ramREN", 32'(ramREN), 0);
    chk("rst_ramWEN", 32'(ramWEN), 0);
    chk("rst_ramaddr", ramaddr, 0);
    chk("rst_iwait", 32'(iwait), 0);
    chk("rst_dwait", 32'(dwait), 0);
    chk("rst_arb_err", 32'(arb_err), 0);
    @(negedge CLK) nRST = 1'b1;

    // fetch with BUSY x2 then ACCESS
    tick(); iREN = 1; iaddr = 32'h40; ramstate = BUSY; smp();
    chk("f_idle_ramREN", 32'(ramREN), 0);
    chk("f_idle_iwait", 32'(iwait), 1);
    tick(); smp();
    chk("f_gnt_ramREN", 32'(ramREN), 1);
    chk("f_gnt_ramaddr", ramaddr, 32'h40);
    chk("f_busy1_iwait", 32'(iwait), 1);
    tick(); smp();
    chk("f_busy2_iwait", 32'(iwait), 1);
    tick(); ramstate = ACCESS; ramload = 32'h8C010004; smp();
    chk("f_acc_iwait", 32'(iwait), 0);
    chk("f_acc_iload", iload, 32'h8C010004);
    chk("f_acc_dload", dload, 0);
    tick(); iREN = 0; ramstate = FREE; smp();
    chk("f_drop_ramREN", 32'(ramREN), 0);

    // simultaneous requests: data first, then fetch with no bubble
    tick(); iREN = 1; dREN = 1; daddr = 32'h100; smp();
    chk("both_idle_ramREN", 32'(ramREN), 0);
    chk("both_idle_dwait", 32'(dwait), 1);
    tick(); ramstate = ACCESS; ramload = 32'h12345678; smp();
    chk("both_d_ramaddr", ramaddr, 32'h100);
    chk("both_d_dwait", 32'(dwait), 0);
    chk("both_d_dload", dload, 32'h12345678);
    chk("both_d_iload", iload, 0);
    chk("both_d_iwait", 32'(iwait), 1);
    #1 dREN = 0;
    tick(); ramstate = BUSY; smp();
    chk("both_i_ramaddr", ramaddr, 32'h40);
    chk("both_i_ramREN", 32'(ramREN), 1);
    tick(); ramstate = ACCESS; smp();
    chk("both_i_iwait", 32'(iwait), 0);
    tick(); iREN = 0; ramstate = FREE; smp();

    // starvation: D,D,D,D,I repeating with ACCESS every 2nd cycle
    tick(); iREN = 1; dREN = 1; ramstate = BUSY; smp();
    for (int g = 0; g < 10; g++) begin
      tick(); ramstate = BUSY; smp();
      chk($sformatf("stv%0d_addr", g), ramaddr, (g % 5 == 4) ? 32'h40 : 32'h100);
      tick(); ramstate = ACCESS; smp();
      chk($sformatf("stv%0d_iwait", g), 32'(iwait), (g % 5 == 4) ? 0 : 1);
      chk($sformatf("stv%0d_dwait", g), 32'(dwait), (g % 5 == 4) ? 1 : 0);
    end

    // read+write together acts as a write
    tick(); dWEN = 1; daddr = 32'h200; dstore = 32'hDEADBEEF; ramstate = BUSY; smp();
    chk("wr_ramWEN", 32'(ramWEN), 1);
    chk("wr_ramREN", 32'(ramREN), 0);
    chk("wr_ramstore", ramstore, 32'hDEADBEEF);
    chk("wr_ramaddr", ramaddr, 32'h200);
    chk("wr_busy_dwait", 32'(dwait), 1);
    tick(); ramstate = ACCESS; smp();
    chk("wr_acc_dwait", 32'(dwait), 0);

    // data withdraws mid-grant; pending fetch is granted next
    tick(); dREN = 0; dWEN = 0; ramstate = BUSY; smp();
    chk("wd_ramREN", 32'(ramREN), 0);
    chk("wd_ramWEN", 32'(ramWEN), 0);
    chk("wd_dwait", 32'(dwait), 0);
    tick(); ramstate = ACCESS; ramload = 32'h0BADF00D; smp();
    chk("wd_next_ramaddr", ramaddr, 32'h40);
    chk("wd_next_ramREN", 32'(ramREN), 1);
    chk("wd_next_iwait", 32'(iwait), 0);
    chk("wd_next_iload", iload, 32'h0BADF00D);
    tick(); iREN = 0; ramstate = FREE; smp();

    // asynchronous reset mid-grant
    tick(); iREN = 1; ramstate = BUSY; smp();
    tick(); smp();
    chk("ar_pre_ramREN", 32'(ramREN), 1);
    #1 nRST = 1'b0;
    #1;
    chk("ar_ramREN", 32'(ramREN), 0);
    chk("ar_ramaddr", ramaddr, 0);
    chk("ar_iload", iload, 0);
    iREN = 0;
    @(negedge CLK) nRST = 1'b1;

    // stuck ERROR
    tick(); iREN = 1; ramstate = ERROR; ramload = 32'h11111111; smp();
`ifdef ARB_TIMEOUT_EN
    for (int k = 0; k < 9; k++) begin
      tick(); smp();
      chk($sformatf("to%0d_iwait", k), 32'(iwait), (k == 8) ? 0 : 1);
      if (k == 8) chk("to_iload", iload, 32'hBAD1BAD1);
    end
    tick(); iREN = 0; smp();
    chk("to_err_set", 32'(arb_err), 1);
    tick(); tick(); smp();
    chk("to_err_hold", 32'(arb_err), 1);
    #1 nRST = 1'b0;
    #1 chk("to_err_rst", 32'(arb_err), 0);
    @(negedge CLK) nRST = 1'b1;
`else
    for (int k = 0; k < 12; k++) begin
      tick(); smp();
      chk($sformatf("err%0d_iwait", k), 32'(iwait), 1);
    end
    chk("err_ramaddr", ramaddr, 32'h40);
    chk("err_arb_err", 32'(arb_err), 0);
    tick(); iREN = 0; ramstate = FREE; smp();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

endmodule

// File: doc/mem_req_arbiter.md
Name: mem_req_arbiter

Overview:
- Arbitrates the icache (fetch) and dcache (load/store) request ports onto the single RAM port behind the pipeline.
- Uses a registered grant FSM. Data requests have priority; a starvation counter guarantees instruction progress.
- Its iwait/dwait outputs are the ihit/dhit sources consumed by the hazard unit to stall or enable pipeline stages.

Parameters:
STARVE_LIMIT, 4, consecutive data grants allowed while iREN is pending before the instruction side is forced a grant (1..15)
TIMEOUT, 255, cycles a granted transaction may wait for ACCESS before the watchdog fires (ARB_TIMEOUT_EN only, 1..255)

Ports:
CLK  input  1  system clock, rising edge
nRST  input  1  asynchronous active-low reset
iREN  input  1  instruction read request
iaddr  input  32  instruction address (word_t)
iwait  output  1  instruction side stalled; low = iload valid this cycle
iload  output  32  instruction read data
dREN  input  1  data read request
dWEN  input  1  data write request
daddr  input  32  data address
dstore  input  32  data write value
dwait  output  1  data side stalled; low = access complete this cycle
dload  output  32  data read data
ramREN  output  1  RAM read enable
ramWEN  output  1  RAM write enable
ramaddr  output  32  RAM address
ramstore  output  32  RAM write data
ramload  input  32  RAM read data
ramstate  input  2  ramstate_t: FREE, BUSY, ACCESS, ERROR
arb_err  output  1  sticky watchdog error flag

Behaviour:
- FSM states: IDLE, IGNT, DGNT. Reset sets state IDLE, starve_cnt 0, arb_err 0.
- Reset values: ramREN=0, ramWEN=0, ramaddr=0, ramstore=0, iload=0, dload=0. iwait and dwait follow their combinational equations (both 0 while no request is present).
- IDLE transitions:
  - dREN|dWEN and starve_cnt<STARVE_LIMIT -> DGNT
  - else iREN -> IGNT
  - else stay IDLE
  - RAM outputs are 0 in IDLE, so a request costs one arbitration cycle.
- IGNT outputs: ramREN=iREN, ramaddr=iaddr, ramWEN=0.
- DGNT outputs:
  - ramaddr=daddr, ramstore=dstore.
  - ramWEN=dWEN; ramREN=dREN&~dWEN. Both asserted is treated as a write.
- Completion: ramstate==ACCESS while granted.
  - iwait = iREN & ~(IGNT & ACCESS).
  - dwait = (dREN|dWEN) & ~(DGNT & ACCESS).
  - iload/dload = ramload passed combinationally from the granted side; 0 on the non-granted side.
- Exit after completion, evaluated with the same priority as IDLE:
  - the other side pending -> go directly to its grant (no bubble);
  - the same side still requesting (next sequential fetch) -> re-grant it;
  - no request -> IDLE.
- starve_cnt:
  - increments (saturating) on each DGNT completion while iREN is high;
  - clears on any IGNT completion or when iREN is low;
  - at STARVE_LIMIT, the next grant decision goes to IGNT even if data is pending.
- BUSY/FREE/ERROR while granted: hold grant and outputs, keep wait high. ERROR is retried indefinitely unless the watchdog is compiled in.
- Requester withdraws (REN/WEN drops) while granted: abort that cycle, RAM enables drop combinationally, next state chosen by normal priority. No completion pulse and no counter change.
- Reset asserted mid-transaction: immediate return to IDLE and all outputs to reset values. Any RAM request is abandoned.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- With it: an 8-bit wd_cnt clears on every grant change and on ACCESS, and increments each granted cycle otherwise. When wd_cnt==TIMEOUT:
  - force completion (wait low one cycle, load=32'hBAD1BAD1);
  - set arb_err sticky until reset;
  - move to the next state by normal priority.
- Without it: no counter; arb_err tied 0; waits are unbounded.

Decomposition:
- arb_state_t (IDLE, IGNT, DGNT) goes in diaosi_types_pkg.
- word_t and ramstate_t come from cpu_types_pkg.
- Single module. The watchdog is inline under the macro; no sub-module is warranted.

Test Plan:
- Reset, then iREN=1, iaddr=0x40, ramstate BUSY x2 then ACCESS, ramload=0x8C010004 -> ramREN rises 1 cycle after iREN; iwait low exactly in the ACCESS cycle; iload=0x8C010004.
- iREN and dREN both raised the same cycle (daddr=0x100) -> DGNT first, ramaddr=0x100; after dwait low, next cycle ramaddr=0x40 with IGNT and no IDLE bubble.
- Continuous dREN plus continuous iREN, ACCESS every 2nd cycle, STARVE_LIMIT=4 -> pattern D,D,D,D,I repeats; iwait low once per 5 grants.
- dREN=1 and dWEN=1, dstore=0xDEADBEEF -> ramWEN=1, ramREN=0, ramstore=0xDEADBEEF.
- dREN dropped mid-DGNT with ramstate BUSY -> ramREN low that cycle; no dwait completion pulse; pending iREN granted next.
- ARB_TIMEOUT_EN, TIMEOUT=8, ramstate stuck ERROR -> iwait low on cycle 8 with iload=0xBAD1BAD1; arb_err=1 and held until nRST; a second test with nRST pulsed mid-grant -> all outputs 0 asynchronously.
